// File: rtl/mul_div_ctrl_seq_pkg.sv
// Shared constants for the single-bus control sequencer: opcodes, IR field
// positions, state encoding and opcode classes.
package mul_div_ctrl_seq_pkg;

  localparam int OPW = 5;
  localparam int RSW = 4;

  // IR field MSB positions
  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RC_MSB = 18;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T4W  = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CL_NOP    = 2'd0,
    CL_ALU    = 2'd1,
    CL_MULDIV = 2'd2,
    CL_HALT   = 2'd3
  } op_class_t;

  // Anything not recognised is treated as a NOP (fetch only).
  function automatic op_class_t classify(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CL_ALU;
      OP_MUL, OP_DIV:                return CL_MULDIV;
      OP_HALT:                       return CL_HALT;
      default:                       return CL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mul_div_ctrl_seq_if.sv
// Datapath-side bundle: IR/handshake inputs to the sequencer and the strobes
// it drives. master = sequencer, slave = datapath.
interface mul_div_ctrl_seq_if;
  import mul_div_ctrl_seq_pkg::*;

  logic [31:0]    ir;
  logic           mem_ready;
  logic           alu_done;

  logic           PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
  logic           Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic           reg_out_en;
  logic [RSW-1:0] reg_out_sel;
  logic           reg_in_en;
  logic [RSW-1:0] reg_in_sel;
  logic [OPW-1:0] alu_op;
  logic           alu_start;
  logic           halted;

  modport master (
    input  ir, mem_ready, alu_done,
    output PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
           alu_op, alu_start, halted
  );

  modport slave (
    output ir, mem_ready, alu_done,
    input  PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, LOin, HIin,
           reg_out_en, reg_out_sel, reg_in_en, reg_in_sel,
           alu_op, alu_start, halted
  );
endinterface

// File: rtl/mul_div_ctrl_seq_decode.sv
// IR field decode: opcode class and the three register selects.
module mul_div_ctrl_seq_decode
  import mul_div_ctrl_seq_pkg::*;
(
  input  logic [31:0]    ir,
  output op_class_t      cls,
  output logic [OPW-1:0] opcode,
  output logic [RSW-1:0] ra,
  output logic [RSW-1:0] rb,
  output logic [RSW-1:0] rc
);

  // Immediate/offset bits are not used by the supported instructions.
  logic unused_imm;
  assign unused_imm = ^ir[IR_RC_MSB-RSW:0];

  assign opcode = ir[IR_OP_MSB -: OPW];
  assign ra     = ir[IR_RA_MSB -: RSW];
  assign rb     = ir[IR_RB_MSB -: RSW];
  assign rc     = ir[IR_RC_MSB -: RSW];
  assign cls    = classify(opcode);

endmodule

// File: rtl/mul_div_ctrl_seq.sv
// Control sequencer for the single-bus datapath: one state per clock, Moore
// strobes decoded from the registered state. run_q keeps every output low
// while in reset and for the remainder of the release cycle; the first fetch
// (T0) is presented after the first clock edge following release.
module mul_div_ctrl_seq
  import mul_div_ctrl_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  mul_div_ctrl_seq_if.master   bus
);

  state_t         state_q, state_d;
  logic           run_q;
  logic           t1_entry_q;
  op_class_t      cls;
  logic [OPW-1:0] opcode;
  logic [RSW-1:0] ra, rb, rc;

  mul_div_ctrl_seq_decode u_dec (
    .ir     (bus.ir),
    .cls    (cls),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc)
  );

  // State register; t1_entry_q marks the first T1 cycle so PCin pulses once
  // even if memory stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_T0;
      run_q      <= 1'b0;
      t1_entry_q <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      t1_entry_q <= run_q && (state_q == S_T0);
      if (run_q) state_q <= state_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d          = state_q;
    bus.PCout        = 1'b0;
    bus.IncPC        = 1'b0;
    bus.PCin         = 1'b0;
    bus.MARin        = 1'b0;
    bus.Read         = 1'b0;
    bus.MDRin        = 1'b0;
    bus.MDRout       = 1'b0;
    bus.IRin         = 1'b0;
    bus.Yin          = 1'b0;
    bus.Zin          = 1'b0;
    bus.Zlowout      = 1'b0;
    bus.Zhighout     = 1'b0;
    bus.LOin         = 1'b0;
    bus.HIin         = 1'b0;
    bus.reg_out_en   = 1'b0;
    bus.reg_out_sel  = '0;
    bus.reg_in_en    = 1'b0;
    bus.reg_in_sel   = '0;
    bus.alu_op       = '0;
    bus.alu_start    = 1'b0;
    bus.halted       = 1'b0;

    if (run_q) begin
      case (state_q)
        S_T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
          state_d   = S_T1;
        end
        S_T1: begin
          bus.Zlowout = 1'b1;
          bus.PCin    = t1_entry_q;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
          if (bus.mem_ready) state_d = S_T2;
        end
        S_T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
          state_d    = S_T3;
        end
        S_T3: begin
          case (cls)
            CL_ALU, CL_MULDIV: begin
              bus.reg_out_en  = 1'b1;
              bus.reg_out_sel = rb;
              bus.Yin         = 1'b1;
              state_d         = S_T4;
            end
            CL_HALT: state_d = S_HALT;
            default: state_d = S_T0;
          endcase
        end
        S_T4: begin
          bus.reg_out_en  = 1'b1;
          bus.reg_out_sel = rc;
          bus.alu_op      = opcode;
          bus.Zin         = 1'b1;
          if (cls == CL_MULDIV) begin
            bus.alu_start = 1'b1;
            state_d       = S_T4W;
          end else begin
            state_d       = S_T5;
          end
        end
        S_T4W: begin
          bus.alu_op = opcode;
          bus.Zin    = 1'b1;
          if (bus.alu_done) state_d = S_T5;
        end
        S_T5: begin
          bus.Zlowout = 1'b1;
          if (cls == CL_MULDIV) begin
            bus.LOin = 1'b1;
            state_d  = S_T6;
          end else begin
            bus.reg_in_en  = 1'b1;
            bus.reg_in_sel = ra;
            state_d        = S_T0;
          end
        end
        S_T6: begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
          state_d      = S_T0;
        end
        S_HALT: begin
          bus.halted = 1'b1;
          state_d    = S_HALT;
        end
        default: state_d = S_T0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_ctrl_seq.sv
// Directed bench for mul_div_ctrl_seq: the stimulus pushes the hand-derived
// strobe word for each cycle into a queue; a negedge monitor pops and compares
// it, and also checks that at most one bus driver is active every cycle.
module tb_mul_div_ctrl_seq;
  import mul_div_ctrl_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_ctrl_seq_if bus();

  mul_div_ctrl_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [30:0] w;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Word layout: {PCout,IncPC,PCin,MARin,Read,MDRin,MDRout,IRin,Yin,Zin,
  //               Zlowout,Zhighout,LOin,HIin, reg_out_en, reg_out_sel,
  //               reg_in_en, reg_in_sel, alu_op, alu_start, halted}
  function automatic logic [30:0] w(input logic [13:0] s, input logic roe,
                                    input logic [3:0] ros, input logic rie,
                                    input logic [3:0] ris, input logic [4:0] op,
                                    input logic st, input logic h);
    return {s, roe, ros, rie, ris, op, st, h};
  endfunction

  function automatic logic [30:0] act();
    return {bus.PCout, bus.IncPC, bus.PCin, bus.MARin, bus.Read, bus.MDRin,
            bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
            bus.LOin, bus.HIin, bus.reg_out_en, bus.reg_out_sel, bus.reg_in_en,
            bus.reg_in_sel, bus.alu_op, bus.alu_start, bus.halted};
  endfunction

  // Monitor: bus-driver exclusivity every cycle, scoreboard compare when queued.
  always @(negedge clk) begin
    logic [30:0] a;
    int          nb;
    exp_t        e;
    a  = act();
    nb = int'(bus.PCout) + int'(bus.Zlowout) + int'(bus.Zhighout)
       + int'(bus.MDRout) + int'(bus.reg_out_en);
    total++;
    if (nb > 1) begin
      bad++;
      $display("FAIL bus_drivers t=%0t actual=%0d required<=1", $time, nb);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (a !== e.w) begin
        bad++;
        $display("FAIL %s t=%0t actual=%h required=%h", e.nm, $time, a, e.w);
      end
    end
  end

  task automatic step(input logic [30:0] e, input string nm);
    @(posedge clk);
    #1;
    sb.push_back('{e, nm});
  endtask

  // Assert reset between clock edges; outputs must drop without a clock.
  task automatic step_rst(input string nm);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    sb.push_back('{31'd0, nm});
  endtask

  logic [30:0] ZERO, T0, T1F, T1H, T2, T3X, T5A, T5M, T6, HLT;

  function automatic logic [30:0] t4(input logic [4:0] op, input logic st);
    return w(14'b00000000010000, 1'b1, 4'd3, 1'b0, 4'd0, op, st, 1'b0);
  endfunction

  function automatic logic [30:0] t4w(input logic [4:0] op);
    return w(14'b00000000010000, 1'b0, 4'd0, 1'b0, 4'd0, op, 1'b0, 1'b0);
  endfunction

  initial begin
    ZERO = '0;
    T0   = w(14'b11010000010000, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T1F  = w(14'b00101100001000, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T1H  = w(14'b00001100001000, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T2   = w(14'b00000011000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T3X  = w(14'b00000000100000, 1'b1, 4'd2, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T5A  = w(14'b00000000001000, 1'b0, 4'd0, 1'b1, 4'd1, 5'd0, 1'b0, 1'b0);
    T5M  = w(14'b00000000001010, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    T6   = w(14'b00000000000101, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
    HLT  = w(14'b00000000000000, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b1);

    reset         = 1'b0;
    bus.ir        = 32'h28918000;   // AND R1,R2,R3
    bus.mem_ready = 1'b1;
    bus.alu_done  = 1'b0;

    // reset state, then release mid-cycle
    step(ZERO, "rst_state");
    step(ZERO, "rst_hold");
    step(ZERO, "rst_release");
    reset = 1'b1;

    // 1: AND with immediate memory
    step(T0, "t1_T0");
    step(T1F, "t1_T1");
    step(T2, "t1_T2");
    step(T3X, "t1_T3");
    step(t4(OP_AND, 1'b0), "t1_T4");
    step(T5A, "t1_T5");
    step(T0, "t1_back_T0");

    // 2: memory stall three cycles in T1; stray alu_done in T2
    step(T1F, "t2_T1_entry");
    bus.mem_ready = 1'b0;
    step(T1H, "t2_T1_hold1");
    step(T1H, "t2_T1_hold2");
    step(T1H, "t2_T1_hold3");
    bus.mem_ready = 1'b1;
    step(T2, "t2_T2");
    bus.alu_done = 1'b1;
    step(T3X, "t2_T3");
    bus.alu_done = 1'b0;
    step(t4(OP_AND, 1'b0), "t2_T4");
    step(T5A, "t2_T5");
    step(T0, "t2_T0");
    bus.ir = 32'h80918000;          // DIV R1,R2,R3

    // 3: DIV, alu_done five clocks after alu_start
    step(T1F, "t3_T1");
    step(T2, "t3_T2");
    step(T3X, "t3_T3");
    step(t4(OP_DIV, 1'b1), "t3_T4_start");
    for (int i = 1; i <= 5; i++) begin
      step(t4w(OP_DIV), $sformatf("t3_T4W_%0d", i));
      bus.alu_done = (i == 5);
    end
    step(T5M, "t3_T5_LOin");
    bus.alu_done = 1'b0;
    step(T6, "t3_T6_HIin");
    step(T0, "t3_T0");
    bus.ir = 32'hD8000000;          // HALT

    // 4: HALT holds for 20 cycles regardless of handshake inputs
    step(T1F, "t4_T1");
    step(T2, "t4_T2");
    step(ZERO, "t4_T3");
    for (int i = 0; i < 20; i++) begin
      step(HLT, $sformatf("t4_halt_%0d", i));
      bus.alu_done  = (i == 3);
      bus.mem_ready = (i != 7);
    end
    step_rst("t4_rst");
    step(ZERO, "t4_rst_hold");
    reset = 1'b1;
    bus.ir = 32'h78918000;          // MUL R1,R2,R3
    step(T0, "t4_resume_T0");

    // 5: async reset while waiting in T4W
    step(T1F, "t5_T1");
    step(T2, "t5_T2");
    step(T3X, "t5_T3");
    step(t4(OP_MUL, 1'b1), "t5_T4_start");
    step(t4w(OP_MUL), "t5_T4W");
    step_rst("t5_async_rst");
    step(ZERO, "t5_rst_hold");
    reset = 1'b1;
    bus.ir = 32'h30918000;          // OR R1,R2,R3
    step(T0, "t5_T0");
    step(T1F, "t5_or_T1");
    step(T2, "t5_or_T2");
    step(T3X, "t5_or_T3");
    step(t4(OP_OR, 1'b0), "t5_or_T4");
    step(T5A, "t5_or_T5");
    step(T0, "t5_or_T0");

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
